// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle control FSM: state codes,
// opcode constants and the datapath select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_AUIPC    = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13,
    S_JALR     = 4'd14,
    S_JALRPC   = 4'd15
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // result_src: which value is written back / forwarded
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Bundle of datapath enables and selects produced by the control FSM.
interface mc_control_fsm_if;
  logic       branch;
  logic       pc_update;
  logic       reg_write;
  logic       mem_write;
  logic       ir_write;
  logic       adr_src;
  logic       illegal;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;

  modport master (
    output branch, pc_update, reg_write, mem_write, ir_write, adr_src, illegal,
    output result_src, alu_src_a, alu_src_b, alu_op
  );

  modport slave (
    input branch, pc_update, reg_write, mem_write, ir_write, adr_src, illegal,
    input result_src, alu_src_a, alu_src_b, alu_op
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control decode. kill_i forces every output low so
// nothing leaks out of FETCH while reset is held.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t                  state_i,
  input  logic                    ready_i,
  input  logic                    kill_i,
  mc_control_fsm_if.master        ctl_o
);

  always_comb begin
    ctl_o.branch     = 1'b0;
    ctl_o.pc_update  = 1'b0;
    ctl_o.reg_write  = 1'b0;
    ctl_o.mem_write  = 1'b0;
    ctl_o.ir_write   = 1'b0;
    ctl_o.adr_src    = 1'b0;
    ctl_o.illegal    = 1'b0;
    ctl_o.result_src = RES_ALUOUT;
    ctl_o.alu_src_a  = SRCA_PC;
    ctl_o.alu_src_b  = SRCB_RS2;
    ctl_o.alu_op     = ALUOP_ADD;
    if (!kill_i) begin
      case (state_i)
        S_FETCH: begin
          ctl_o.alu_src_b  = SRCB_FOUR;
          ctl_o.result_src = RES_ALURES;
          ctl_o.ir_write   = ready_i;
          ctl_o.pc_update  = ready_i;
        end
        S_DECODE: begin
          ctl_o.alu_src_a = SRCA_OLDPC;
          ctl_o.alu_src_b = SRCB_IMM;
        end
        S_MEMADR: begin
          ctl_o.alu_src_a = SRCA_RS1;
          ctl_o.alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: ctl_o.adr_src = 1'b1;
        S_MEMWB: begin
          ctl_o.reg_write  = 1'b1;
          ctl_o.result_src = RES_DATA;
        end
        S_MEMWRITE: begin
          ctl_o.adr_src   = 1'b1;
          ctl_o.mem_write = 1'b1;
        end
        S_EXECR: begin
          ctl_o.alu_src_a = SRCA_RS1;
          ctl_o.alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          ctl_o.reg_write  = 1'b1;
          ctl_o.result_src = RES_ALUOUT;
        end
        S_EXECI: begin
          ctl_o.alu_src_a = SRCA_RS1;
          ctl_o.alu_src_b = SRCB_IMM;
          ctl_o.alu_op    = ALUOP_FUNCT;
        end
        S_JAL: begin
          ctl_o.pc_update = 1'b1;
          ctl_o.alu_src_a = SRCA_OLDPC;
          ctl_o.alu_src_b = SRCB_FOUR;
        end
        S_BEQ: begin
          ctl_o.branch    = 1'b1;
          ctl_o.alu_src_a = SRCA_RS1;
          ctl_o.alu_op    = ALUOP_SUB;
        end
        S_AUIPC: begin
          ctl_o.alu_src_a = SRCA_OLDPC;
          ctl_o.alu_src_b = SRCB_IMM;
        end
        S_LUI: begin
          ctl_o.reg_write  = 1'b1;
          ctl_o.result_src = RES_IMM;
        end
        S_TRAP: ctl_o.illegal = 1'b1;
        // JALR is split: link write first, then the PC redirect to rs1+imm
        S_JALR: begin
          ctl_o.alu_src_a  = SRCA_OLDPC;
          ctl_o.alu_src_b  = SRCB_FOUR;
          ctl_o.result_src = RES_ALURES;
          ctl_o.reg_write  = 1'b1;
        end
        S_JALRPC: begin
          ctl_o.alu_src_a  = SRCA_RS1;
          ctl_o.alu_src_b  = SRCB_IMM;
          ctl_o.result_src = RES_ALURES;
          ctl_o.pc_update  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V style control FSM: next-state logic, retired-instruction
// counter and the control decode sub-module.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int USE_READY = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  input  logic             trap_ack,
  output logic             branch,
  output logic             pc_update,
  output logic             reg_write,
  output logic             mem_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             ready;
  logic             retire;

  // mem_ready is a single-cycle completion strobe: a FETCH/MEMREAD/MEMWRITE
  // access finishes in the cycle it is seen high, and the state moves on.
  assign ready = (USE_READY != 0) ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_AUIPC: state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRPC;
      S_TRAP:     if (trap_ack) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_LUI, S_BEQ, S_JALRPC: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Every return to FETCH completes an instruction, except leaving TRAP.
  assign retire    = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP);
  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  mc_control_fsm_if ctl_if ();

  mc_ctrl_outdec u_outdec (
    .state_i (state_q),
    .ready_i (ready),
    .kill_i  (rst),
    .ctl_o   (ctl_if)
  );

  assign branch     = ctl_if.branch;
  assign pc_update  = ctl_if.pc_update;
  assign reg_write  = ctl_if.reg_write;
  assign mem_write  = ctl_if.mem_write;
  assign ir_write   = ctl_if.ir_write;
  assign adr_src    = ctl_if.adr_src;
  assign illegal    = ctl_if.illegal;
  assign result_src = ctl_if.result_src;
  assign alu_src_a  = ctl_if.alu_src_a;
  assign alu_src_b  = ctl_if.alu_src_b;
  assign alu_op     = ctl_if.alu_op;
  assign state_o    = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-path model checked every cycle plus
// directed scenarios with literal expectations.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  localparam int TB_CNT_W = 4;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [6:0] op_nr = OP_LOAD;
  logic mem_ready = 1'b0;
  logic trap_ack = 1'b0;
  logic nr_ready = 1'b0;
  logic [3:0] state_o, nr_state;
  logic [TB_CNT_W-1:0] retired;
  logic [31:0] nr_retired;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_control_fsm_if ctl_if ();
  mc_control_fsm_if nr_if ();

  mc_control_fsm #(.USE_READY(1), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready), .trap_ack(trap_ack),
    .branch(ctl_if.branch), .pc_update(ctl_if.pc_update), .reg_write(ctl_if.reg_write),
    .mem_write(ctl_if.mem_write), .ir_write(ctl_if.ir_write), .adr_src(ctl_if.adr_src),
    .result_src(ctl_if.result_src), .alu_src_a(ctl_if.alu_src_a),
    .alu_src_b(ctl_if.alu_src_b), .alu_op(ctl_if.alu_op), .illegal(ctl_if.illegal),
    .state_o(state_o), .retired(retired)
  );

  mc_control_fsm #(.USE_READY(0), .CNT_W(32)) dut_nr (
    .clk(clk), .rst(rst), .op(op_nr), .mem_ready(nr_ready), .trap_ack(trap_ack),
    .branch(nr_if.branch), .pc_update(nr_if.pc_update), .reg_write(nr_if.reg_write),
    .mem_write(nr_if.mem_write), .ir_write(nr_if.ir_write), .adr_src(nr_if.adr_src),
    .result_src(nr_if.result_src), .alu_src_a(nr_if.alu_src_a),
    .alu_src_b(nr_if.alu_src_b), .alu_op(nr_if.alu_op), .illegal(nr_if.illegal),
    .state_o(nr_state), .retired(nr_retired)
  );

  logic [14:0] act_ctrl;
  assign act_ctrl = {ctl_if.branch, ctl_if.pc_update, ctl_if.reg_write, ctl_if.mem_write,
                     ctl_if.ir_write, ctl_if.adr_src, ctl_if.illegal, ctl_if.result_src,
                     ctl_if.alu_src_a, ctl_if.alu_src_b, ctl_if.alu_op};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the micro-op path of the current instruction as a queue of state
  // numbers; the control word per state comes from a table of the rules.
  int m_state = 0;
  int m_retired = 0;
  int m_path[$];

  function automatic logic [14:0] exp_ctrl(input int st, input logic rdy);
    logic br, pc, rw, mw, ir, ad, il;
    logic [1:0] rs, sa, sb, ao;
    {br, pc, rw, mw, ir, ad, il} = 7'd0;
    rs = 2'd0; sa = 2'd0; sb = 2'd0; ao = 2'd0;
    case (st)
      0:  begin rs = 2; sb = 2; ir = rdy; pc = rdy; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  ad = 1;
      4:  begin rw = 1; rs = 1; end
      5:  begin ad = 1; mw = 1; end
      6:  begin sa = 2; ao = 2; end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; ao = 2; end
      9:  begin pc = 1; sa = 1; sb = 2; end
      10: begin br = 1; sa = 2; ao = 1; end
      11: begin sa = 1; sb = 1; end
      12: begin rw = 1; rs = 3; end
      13: il = 1;
      14: begin sa = 1; sb = 2; rs = 2; rw = 1; end
      15: begin sa = 2; sb = 1; rs = 2; pc = 1; end
      default: ;
    endcase
    return {br, pc, rw, mw, ir, ad, il, rs, sa, sb, ao};
  endfunction

  task automatic load_path(input logic [6:0] o);
    m_path.delete();
    case (o)
      OP_RTYPE:  begin m_path.push_back(6);  m_path.push_back(7); end
      OP_ITYPE:  begin m_path.push_back(8);  m_path.push_back(7); end
      OP_LOAD:   begin m_path.push_back(2);  m_path.push_back(3); m_path.push_back(4); end
      OP_STORE:  begin m_path.push_back(2);  m_path.push_back(5); end
      OP_BRANCH: m_path.push_back(10);
      OP_JAL:    begin m_path.push_back(9);  m_path.push_back(7); end
      OP_JALR:   begin m_path.push_back(14); m_path.push_back(15); end
      OP_AUIPC:  begin m_path.push_back(11); m_path.push_back(7); end
      OP_LUI:    m_path.push_back(12);
      default:   m_path.push_back(13);
    endcase
  endtask

  task automatic model_next();
    if (m_path.size() == 0) begin
      if (m_state != 13) m_retired = (m_retired + 1) % (1 << TB_CNT_W);
      m_state = 0;
    end else begin
      m_state = m_path.pop_front();
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0;
      m_retired = 0;
      m_path.delete();
    end else begin
      case (m_state)
        0:       if (mem_ready) m_state = 1;
        1:       begin load_path(op); m_state = m_path.pop_front(); end
        3, 5:    if (mem_ready) model_next();
        13:      if (trap_ack) model_next();
        default: model_next();
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [14:0] e;
    int es, er;
    if (rst) begin
      e = '0; es = 0; er = 0;
    end else begin
      e = exp_ctrl(m_state, mem_ready); es = m_state; er = m_retired;
    end
    chk("cyc_state", 32'(state_o), 32'(es));
    chk("cyc_ctrl", 32'(act_ctrl), 32'(e));
    chk("cyc_retired", 32'(retired), 32'(er));
  end

  // ---------------- driver / observation ----------------
  typedef struct {
    int   st;
    int   ret;
    logic rw, pc, mw, il, any_en;
  } obs_t;
  obs_t obs_q[$];

  task automatic step(input logic rdy, input logic ack);
    obs_t o;
    @(posedge clk); #2;
    mem_ready = rdy;
    trap_ack  = ack;
    @(negedge clk); #1;
    o.st = int'(state_o);
    o.ret = int'(retired);
    o.rw = ctl_if.reg_write;
    o.pc = ctl_if.pc_update;
    o.mw = ctl_if.mem_write;
    o.il = ctl_if.illegal;
    o.any_en = ctl_if.branch | ctl_if.pc_update | ctl_if.reg_write |
               ctl_if.mem_write | ctl_if.ir_write | ctl_if.adr_src;
    obs_q.push_back(o);
  endtask

  task automatic run_op(input logic [6:0] o, input int n_after);
    op = o;
    step(1'b1, 1'b0);
    for (int k = 0; k < n_after; k++) step(1'b0, 1'b0);
  endtask

  int seq_a[6]  = '{0, 1, 2, 3, 4, 0};
  int seq_b[8]  = '{0, 1, 2, 5, 5, 5, 5, 0};
  int seq_c[5]  = '{0, 1, 14, 15, 0};
  int seq_nr[6] = '{0, 1, 2, 3, 4, 0};
  logic [6:0] mix_ops[5] = '{OP_ITYPE, OP_BRANCH, OP_JAL, OP_AUIPC, OP_LUI};
  int mix_len[5] = '{3, 2, 3, 3, 2};

  initial begin
    int mw_cnt;
    logic [3:0] nr_seen[$];

    // reset: everything low, FETCH selects suppressed
    #3;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ctrl", 32'(act_ctrl), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    // USE_READY=0 instance: load completes with mem_ready tied low
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      nr_seen.push_back(nr_state);
      if (i == 0) chk("nr_fetch_ir_write", 32'(nr_if.ir_write), 32'd1);
    end
    for (int i = 0; i < 6; i++) chk("nr_load_seq", 32'(nr_seen[i]), 32'(seq_nr[i]));
    chk("nr_retired", nr_retired, 32'd1);
    op_nr = 7'h7f;

    // load, mem_ready high throughout
    obs_q.delete();
    op = OP_LOAD;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("ld_seq", 32'(obs_q[i].st), 32'(seq_a[i]));
      chk("ld_reg_write", 32'(obs_q[i].rw), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("ld_retired", 32'(obs_q[5].ret), 32'd1);

    // store, acceptance held off for 3 cycles
    obs_q.delete();
    op = OP_STORE;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    mw_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      chk("st_seq", 32'(obs_q[i].st), 32'(seq_b[i]));
      if (obs_q[i].mw) mw_cnt++;
    end
    chk("st_mem_write_cycles", 32'(mw_cnt), 32'd4);
    chk("st_mem_write_drop", 32'(obs_q[7].mw), 32'd0);
    chk("st_retired", 32'(obs_q[7].ret), 32'd2);

    // jalr split into link write then PC redirect
    obs_q.delete();
    op = OP_JALR;
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("jalr_seq", 32'(obs_q[i].st), 32'(seq_c[i]));
      chk("jalr_reg_write", 32'(obs_q[i].rw), (i == 2) ? 32'd1 : 32'd0);
      if (i > 0) chk("jalr_pc_update", 32'(obs_q[i].pc), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("jalr_retired", 32'(obs_q[4].ret), 32'd3);

    // illegal opcode: park in TRAP, release on trap_ack, no retire
    obs_q.delete();
    op = 7'b1111111;
    step(1'b1, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 2; i < 12; i++) begin
      chk("trap_state", 32'(obs_q[i].st), 32'd13);
      chk("trap_illegal", 32'(obs_q[i].il), 32'd1);
      chk("trap_no_enables", 32'(obs_q[i].any_en), 32'd0);
    end
    chk("trap_held_at_ack", 32'(obs_q[12].st), 32'd13);
    chk("trap_exit", 32'(obs_q[13].st), 32'd0);
    chk("trap_ack_ignored_in_fetch", 32'(obs_q[14].st), 32'd0);
    chk("trap_retired", 32'(obs_q[14].ret), 32'd3);

    // reset asserted while waiting in MEMREAD
    obs_q.delete();
    op = OP_LOAD;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_pre_memread", 32'(obs_q[3].st), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_state", 32'(state_o), 32'd0);
    chk("rst_mid_ctrl", 32'(act_ctrl), 32'd0);
    chk("rst_mid_retired", 32'(retired), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // 16 R-type instructions wrap the 4-bit counter back to 0
    for (int i = 0; i < 16; i++) run_op(OP_RTYPE, 3);
    obs_q.delete();
    step(1'b0, 1'b0);
    chk("wrap_state", 32'(obs_q[0].st), 32'd0);
    chk("wrap_retired", 32'(obs_q[0].ret), 32'd0);

    // remaining instruction classes, checked cycle by cycle by the model
    for (int i = 0; i < 5; i++) run_op(mix_ops[i], mix_len[i]);
    obs_q.delete();
    step(1'b0, 1'b0);
    chk("mix_state", 32'(obs_q[0].st), 32'd0);
    chk("mix_retired", 32'(obs_q[0].ret), 32'd5);

    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter USE_READY, default 1, meaning memory states wait on mem_ready; 0 treats mem_ready as constant 1.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the retired-instruction counter.
REQ-003 SHALL have ports, one per line:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
op  input  7  opcode field of the instruction register.
mem_ready  input  1  memory access completes this cycle.
trap_ack  input  1  software/host acknowledges an illegal-instruction trap.
branch, pc_update, reg_write, mem_write, ir_write, adr_src  output  1 each  datapath enables and selects.
result_src, alu_src_a, alu_src_b, alu_op  output  2 each  datapath selects.
illegal  output  1  FSM is in TRAP.
state_o  output  4  current state code, for debug.
retired  output  CNT_W  count of completed instructions.

Function
REQ-004 SHALL use the state codes FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, AUIPC=11, LUI=12, TRAP=13, JALR=14, JALRPC=15.
REQ-005 SHALL have FETCH stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-006 SHALL have FETCH drive alu_src_b=10 and result_src=10 in every cycle, and assert ir_write and pc_update only in the mem_ready=1 cycle.
REQ-007 SHALL, in DECODE, dispatch on op: 0110011 -> EXECR; 0010011 -> EXECI; 0000011 or 0100011 -> MEMADR; 1100011 -> BEQ; 1101111 -> JAL; 1100111 -> JALR; 0010111 -> AUIPC; 0110111 -> LUI; any other value -> TRAP.
REQ-008 SHALL have DECODE drive alu_src_a=01 and alu_src_b=01.
REQ-009 SHALL have MEMADR drive alu_src_a=10 and alu_src_b=01, then go to MEMWRITE if op[5]=1, else to MEMREAD.
REQ-010 SHALL have MEMREAD drive adr_src=1, hold until mem_ready=1, then go to MEMWB.
REQ-011 SHALL have MEMWB drive reg_write=1 and result_src=01, then go to FETCH.
REQ-012 SHALL have MEMWRITE drive adr_src=1 and mem_write=1 in every cycle until mem_ready=1, then go to FETCH; mem_write SHALL drop in the cycle after acceptance.
REQ-013 SHALL have EXECR drive alu_src_a=10 and alu_op=10; EXECI SHALL drive the same plus alu_src_b=01; both SHALL then go to ALUWB.
REQ-014 SHALL have ALUWB drive reg_write=1 and result_src=00, then go to FETCH.
REQ-015 SHALL have JAL drive pc_update=1, alu_src_a=01 and alu_src_b=10, then go to ALUWB.
REQ-016 SHALL have AUIPC drive alu_src_a=01 and alu_src_b=01, then go to ALUWB.
REQ-017 SHALL have LUI drive reg_write=1 and result_src=11, then go to FETCH.
REQ-018 SHALL have BEQ drive branch=1, alu_src_a=10 and alu_op=01, then go to FETCH.
REQ-019 SHALL have JALR drive alu_src_a=01, alu_src_b=10, result_src=10 and reg_write=1 (rd <= OldPC+4), then go to JALRPC.
REQ-020 SHALL have JALRPC drive alu_src_a=10, alu_src_b=01, result_src=10 and pc_update=1 (PC <= rs1+imm), then go to FETCH.
REQ-021 SHALL have TRAP drive illegal=1 with every enable at 0 (never X); it SHALL hold until trap_ack=1, then go to FETCH.
REQ-022 SHALL drive every output not listed for a state to 0.
REQ-023 SHALL have all outputs depend only on state, plus mem_ready in FETCH.
REQ-024 SHALL increment retired by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, LUI, BEQ or JALRPC.
REQ-025 SHALL NOT increment retired on the TRAP -> FETCH transition.
REQ-026 SHALL wrap retired from all-ones to 0.
REQ-027 SHALL, when USE_READY=0, make FETCH, MEMREAD and MEMWRITE single-cycle states.
REQ-028 SHALL ignore trap_ack outside TRAP.

Reset
REQ-029 SHALL, on rst, asynchronously set state=FETCH and retired=0.
REQ-030 SHALL, while rst is asserted, hold every control output at 0, including FETCH's selects.
REQ-031 SHALL, when rst asserts mid-instruction (including during MEMWRITE), abort the instruction and deassert mem_write immediately.

Structure
REQ-032 SHALL place the state enum, the opcode constants and the result_src/alu_src/alu_op encodings in package mc_ctrl_pkg.
REQ-033 SHALL implement the state-to-control decode in combinational sub-module mc_ctrl_outdec; the next-state logic and counter SHALL remain in mc_control_fsm.

Verification
REQ-034 SHALL verify: op=0000011 with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; retired=1.
REQ-035 SHALL verify: op=0100011 with mem_ready low 3 cycles in MEMWRITE -> mem_write high exactly 4 cycles; then FETCH; retired+1.
REQ-036 SHALL verify: op=1100111 -> states 1,14,15,0; reg_write only in 14; pc_update only in 15.
REQ-037 SHALL verify: op=1111111 -> TRAP, illegal=1, no enables for 10 cycles; trap_ack=1 -> FETCH; retired unchanged.
REQ-038 SHALL verify: CNT_W=4 after 16 R-type instructions -> retired=0 (wrap).
REQ-039 SHALL verify: rst asserted during MEMREAD -> state_o=0 and all outputs 0 in the same cycle.
